// File: rtl/apb_uart_rx_fifo_subordinate.sv
// APB register slave for the UART RX path: buffers characters in a FIFO, holds sticky W1C errors, sets bit period and data size.
// Optional APB_UART_RX_IRQ_EN adds the IRQ_EN register at address 7 and a registered interrupt output.
module apb_uart_rx_fifo_subordinate #(
  parameter int FIFO_DEPTH = 8,
  parameter int BP_W       = 14,
  parameter int BP_RESET   = 10
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            rx_valid,
  input  logic [7:0]      rx_data,
  input  logic            framing_err,
  input  logic            overrun_err,
  input  logic            psel,
  input  logic            penable,
  input  logic            pwrite,
  input  logic [2:0]      paddr,
  input  logic [7:0]      pwdata,
  output logic [7:0]      prdata,
  output logic            pready,
  output logic            pslverr,
  output logic [BP_W-1:0] bit_period,
  output logic [3:0]      data_size,
  output logic            irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [2:0]    err_q;
  logic          xfer_q;
  logic          rd_empty_q;
  logic          empty, full;
  logic          setup, access, wr_ok, pop, push, ovf;
  logic [7:0]    rd_val;
  logic [7:0]    rx_mask;
  logic [2:0]    err_set, err_clr;

  assign pready = 1'b1;
  assign empty  = (count == '0);
  assign full   = (count == CW'(FIFO_DEPTH));
  assign setup  = psel & ~penable;
  // Access only counts if its setup edge was seen, so a reset mid-transfer aborts it.
  assign access = psel & penable & xfer_q;

  always_comb begin
    pslverr = 1'b0;
    if (access) begin
      case (paddr)
        3'd0, 3'd5: pslverr = pwrite;
        3'd6:       pslverr = pwrite | rd_empty_q;
        3'd4:       pslverr = pwrite & ((pwdata[3:0] < 4'd5) | (pwdata[3:0] > 4'd8));
`ifdef APB_UART_RX_IRQ_EN
        3'd7:       pslverr = 1'b0;
`else
        3'd7:       pslverr = 1'b1;
`endif
        default:    pslverr = 1'b0;
      endcase
    end
  end

  assign wr_ok = access & pwrite & ~pslverr;
  assign pop   = access & ~pwrite & (paddr == 3'd6) & ~rd_empty_q;
  assign push  = rx_valid & (~full | pop);
  assign ovf   = rx_valid & full & ~pop;

  always_comb begin
    rx_mask = '0;
    for (int i = 0; i < 8; i++) rx_mask[i] = (4'(i) < data_size);
  end

  assign err_set = rx_valid ? {ovf, overrun_err, framing_err} : 3'b000;
  assign err_clr = (wr_ok && paddr == 3'd1) ? pwdata[2:0] : 3'b000;

`ifdef APB_UART_RX_IRQ_EN
  logic [2:0] irq_en;
`endif

  always_comb begin
    rd_val = '0;
    case (paddr)
      3'd0: rd_val = {6'd0, full, ~empty};
      3'd1: rd_val = {5'd0, err_q};
      3'd2: rd_val = bit_period[7:0];
      3'd3: rd_val = 8'(bit_period[BP_W-1:8]);
      3'd4: rd_val = {4'd0, data_size};
      3'd5: rd_val = 8'(count);
      3'd6: rd_val = empty ? 8'h00 : mem[rd_ptr];
`ifdef APB_UART_RX_IRQ_EN
      3'd7: rd_val = {5'd0, irq_en};
`endif
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prdata     <= '0;
      xfer_q     <= 1'b0;
      rd_empty_q <= 1'b0;
    end else begin
      prdata     <= setup ? rd_val : 8'h00;
      xfer_q     <= setup;
      if (setup) rd_empty_q <= empty;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data & rx_mask;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= AW'(wr_ptr + 1'b1);
      if (pop)  rd_ptr <= AW'(rd_ptr + 1'b1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Set wins over a coincident W1C clear.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err_q      <= '0;
      bit_period <= BP_W'(BP_RESET);
      data_size  <= 4'd8;
    end else begin
      err_q <= (err_q & ~err_clr) | err_set;
      if (wr_ok && paddr == 3'd2) bit_period[7:0]      <= pwdata;
      if (wr_ok && paddr == 3'd3) bit_period[BP_W-1:8] <= pwdata[BP_W-9:0];
      if (wr_ok && paddr == 3'd4) data_size            <= pwdata[3:0];
    end
  end

`ifdef APB_UART_RX_IRQ_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      irq_en <= '0;
      irq    <= 1'b0;
    end else begin
      if (wr_ok && paddr == 3'd7) irq_en <= pwdata[2:0];
      irq <= |(irq_en & {full, |err_q, ~empty});
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_apb_uart_rx_fifo_subordinate.sv
// Directed bench for apb_uart_rx_fifo_subordinate; IRQ checks follow APB_UART_RX_IRQ_EN.
module tb_apb_uart_rx_fifo_subordinate;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        framing_err = 1'b0;
  logic        overrun_err = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [2:0]  paddr = '0;
  logic [7:0]  pwdata = '0;
  logic [7:0]  prdata;
  logic        pready;
  logic        pslverr;
  logic [13:0] bit_period;
  logic [3:0]  data_size;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [7:0] rd;
  logic       er;

  apb_uart_rx_fifo_subordinate dut (
    .clk(clk), .n_rst(n_rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .framing_err(framing_err), .overrun_err(overrun_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .bit_period(bit_period), .data_size(data_size), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One APB transfer; optionally a character arrives during the access cycle.
  task automatic xfer(input logic wr, input logic [2:0] a, input logic [7:0] wd,
                      input logic pu, input logic [7:0] pd, input logic fe,
                      output logic [7:0] rdat, output logic rerr);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1; rx_valid = pu; rx_data = pd; framing_err = fe;
    #1;
    rdat = prdata; rerr = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; rx_valid = 1'b0; framing_err = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp, input logic exp_err);
    logic [7:0] d;
    logic e;
    xfer(1'b0, a, 8'h00, 1'b0, 8'h00, 1'b0, d, e);
    check({tag, ".data"}, 16'(d), 16'(exp));
    check({tag, ".slverr"}, 16'(e), 16'(exp_err));
  endtask

  task automatic wr_chk(input string tag, input logic [2:0] a, input logic [7:0] wd, input logic exp_err);
    logic [7:0] d;
    logic e;
    xfer(1'b1, a, wd, 1'b0, 8'h00, 1'b0, d, e);
    check({tag, ".slverr"}, 16'(e), 16'(exp_err));
  endtask

  task automatic push(input logic [7:0] d, input logic fe);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = d; framing_err = fe;
    @(posedge clk); #1;
    rx_valid = 1'b0; framing_err = 1'b0;
  endtask

  initial begin
    #22;
    check("rst.prdata", 16'(prdata), 16'h0);
    check("rst.pslverr", 16'(pslverr), 16'h0);
    check("rst.irq", 16'(irq), 16'h0);
    n_rst = 1'b1;

    rd_chk("rst.bp_lo", 3'd2, 8'h0A, 1'b0);
    rd_chk("rst.bp_hi", 3'd3, 8'h00, 1'b0);
    rd_chk("rst.dsize", 3'd4, 8'h08, 1'b0);
    rd_chk("rst.level", 3'd5, 8'h00, 1'b0);
    rd_chk("rst.status", 3'd0, 8'h00, 1'b0);
    rd_chk("rst.error", 3'd1, 8'h00, 1'b0);
    check("idle.prdata", 16'(prdata), 16'h0);

    // Basic push / pop order and empty-read error.
    push(8'hA5, 1'b0);
    push(8'h3C, 1'b0);
    rd_chk("pp.level2", 3'd5, 8'h02, 1'b0);
    rd_chk("pp.pop1", 3'd6, 8'hA5, 1'b0);
    rd_chk("pp.level1", 3'd5, 8'h01, 1'b0);
    rd_chk("pp.pop2", 3'd6, 8'h3C, 1'b0);
    rd_chk("pp.level0", 3'd5, 8'h00, 1'b0);
    rd_chk("pp.pop_empty", 3'd6, 8'h00, 1'b1);
    rd_chk("pp.level_after", 3'd5, 8'h00, 1'b0);

    // Overflow, then push+pop while full, then drain across the pointer wrap.
    for (int i = 0; i < 9; i++) push(8'(8'h10 + i), 1'b0);
    rd_chk("ov.status", 3'd0, 8'h03, 1'b0);
    rd_chk("ov.level", 3'd5, 8'h08, 1'b0);
    rd_chk("ov.error", 3'd1, 8'h04, 1'b0);
    wr_chk("ov.clr", 3'd1, 8'h04, 1'b0);
    rd_chk("ov.error_clr", 3'd1, 8'h00, 1'b0);
    xfer(1'b0, 3'd6, 8'h00, 1'b1, 8'h55, 1'b0, rd, er);
    check("full_pp.data", 16'(rd), 16'h10);
    check("full_pp.slverr", 16'(er), 16'h0);
    rd_chk("full_pp.level", 3'd5, 8'h08, 1'b0);
    rd_chk("full_pp.error", 3'd1, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++)
      rd_chk($sformatf("drain%0d", i), 3'd6, (i == 7) ? 8'h55 : 8'(8'h11 + i), 1'b0);
    rd_chk("drain.status", 3'd0, 8'h00, 1'b0);

    // Data size masking and illegal writes.
    wr_chk("ds.wr7", 3'd4, 8'h07, 1'b0);
    push(8'hFF, 1'b0);
    rd_chk("ds.masked", 3'd6, 8'h7F, 1'b0);
    wr_chk("ds.wr9", 3'd4, 8'h09, 1'b1);
    wr_chk("ds.wr4", 3'd4, 8'h04, 1'b1);
    rd_chk("ds.kept", 3'd4, 8'h07, 1'b0);
    wr_chk("ds.wr8", 3'd4, 8'h08, 1'b0);
    wr_chk("ro.status", 3'd0, 8'hFF, 1'b1);
    wr_chk("ro.level", 3'd5, 8'hFF, 1'b1);
    wr_chk("ro.rxdata", 3'd6, 8'hFF, 1'b1);

    // Bit period: BP_HI keeps only BP_W-8 bits.
    wr_chk("bp.hi", 3'd3, 8'hFF, 1'b0);
    rd_chk("bp.hi_rd", 3'd3, 8'h3F, 1'b0);
    check("bp.out", 16'(bit_period), 16'h3F0A);

    // Sticky framing error, W1C, and set winning over a coincident clear.
    push(8'h41, 1'b1);
    rd_chk("err.fe", 3'd1, 8'h01, 1'b0);
    wr_chk("err.clr", 3'd1, 8'h01, 1'b0);
    rd_chk("err.cleared", 3'd1, 8'h00, 1'b0);
    xfer(1'b1, 3'd1, 8'h01, 1'b1, 8'h42, 1'b1, rd, er);
    check("err.coinc.slverr", 16'(er), 16'h0);
    rd_chk("err.coinc", 3'd1, 8'h01, 1'b0);
    rd_chk("err.level", 3'd5, 8'h02, 1'b0);
    rd_chk("err.pop1", 3'd6, 8'h41, 1'b0);
    rd_chk("err.pop2", 3'd6, 8'h42, 1'b0);
    wr_chk("err.clr2", 3'd1, 8'h07, 1'b0);

`ifdef APB_UART_RX_IRQ_EN
    wr_chk("irq.en", 3'd7, 8'h01, 1'b0);
    rd_chk("irq.en_rd", 3'd7, 8'h01, 1'b0);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = 8'h77;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    check("irq.lag", 16'(irq), 16'h0);
    @(posedge clk); #1;
    check("irq.set", 16'(irq), 16'h1);
    rd_chk("irq.pop", 3'd6, 8'h77, 1'b0);
    @(posedge clk); #1;
    check("irq.clr", 16'(irq), 16'h0);
`else
    rd_chk("a7.read", 3'd7, 8'h00, 1'b1);
    wr_chk("a7.write", 3'd7, 8'h01, 1'b1);
    push(8'h77, 1'b0);
    @(posedge clk); #1;
    check("irq.tied", 16'(irq), 16'h0);
    rd_chk("a7.pop", 3'd6, 8'h77, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
